// File: rtl/instruction_fetch_unit.sv
// instruction_fetch_unit
//   Fetch stage of a 64-bit in-order pipeline. Drives a byte address to a
//   combinational instruction memory and captures the returned word into the
//   IF/ID pipeline register, one cycle of latency.
//
//   state | meaning
//   ------+-------------------------------------------------------------
//   BOOT  | first cycle out of reset, no capture, PC untouched
//   RUN   | normal fetch, honours branch_taken > flush > stall > fetch
//   FAULT | misaligned branch or fetch past memory end; frozen until reset
//
// Ports
//   clk, reset              rising-edge clock, async active-high reset
//   Inst_Address (out 64)   fetch address, equals PC
//   Instruction  (in  32)   memory word for Inst_Address
//   stall, flush            hold PC + IF/ID / replace IF/ID with a bubble
//   branch_taken, branch_target  PC redirect request and byte target
//   if_id_pc, if_id_instruction, if_id_valid   IF/ID pipeline register
//   fetch_fault (out 1)     sticky fault, high while in FAULT
module instruction_fetch_unit #(
  parameter logic [63:0] RESET_PC  = 64'd0,
  parameter int          MEM_BYTES = 88
) (
  input  logic        clk,
  input  logic        reset,
  output logic [63:0] Inst_Address,
  input  logic [31:0] Instruction,
  input  logic        stall,
  input  logic        flush,
  input  logic        branch_taken,
  input  logic [63:0] branch_target,
  output logic [63:0] if_id_pc,
  output logic [31:0] if_id_instruction,
  output logic        if_id_valid,
  output logic        fetch_fault
);

  localparam logic [1:0] BOOT  = 2'd0;
  localparam logic [1:0] RUN   = 2'd1;
  localparam logic [1:0] FAULT = 2'd2;

  localparam logic [31:0] NOP_INSN = 32'h0000_0013;
  // Highest PC whose full 4-byte word still lies inside the memory.
  localparam logic [63:0] LAST_PC  = 64'(MEM_BYTES - 4);

  logic [1:0]  state_q, state_d;
  logic [63:0] pc_q, pc_d;
  logic [63:0] if_pc_q, if_pc_d;
  logic [31:0] if_insn_q, if_insn_d;
  logic        if_valid_q, if_valid_d;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    if_pc_d    = if_pc_q;
    if_insn_d  = if_insn_q;
    if_valid_d = if_valid_q;

    case (state_q)
      BOOT: begin
        state_d = RUN;
      end

      RUN: begin
        if (branch_taken) begin
          // Redirect wins over flush and stall; a misaligned target freezes PC.
          if_insn_d  = NOP_INSN;
          if_valid_d = 1'b0;
          if (branch_target[1:0] == 2'b00) begin
            pc_d = branch_target;
          end else begin
            state_d = FAULT;
          end
        end else if (flush) begin
          // The word at PC is discarded; PC still advances unless stalled.
          if_insn_d  = NOP_INSN;
          if_valid_d = 1'b0;
          if (!stall) begin
            pc_d = pc_q + 64'd4;
          end
        end else if (!stall) begin
          if (pc_q <= LAST_PC) begin
            if_pc_d    = pc_q;
            if_insn_d  = Instruction;
            if_valid_d = 1'b1;
            pc_d       = pc_q + 64'd4;
          end else begin
            state_d    = FAULT;
            if_insn_d  = NOP_INSN;
            if_valid_d = 1'b0;
          end
        end
      end

      FAULT: begin
        if_valid_d = 1'b0;
      end

      default: begin
        // Unreachable encoding: treat as a fault so nothing is fetched.
        state_d    = FAULT;
        if_insn_d  = NOP_INSN;
        if_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= BOOT;
      pc_q       <= RESET_PC;
      if_pc_q    <= 64'd0;
      if_insn_q  <= NOP_INSN;
      if_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      if_pc_q    <= if_pc_d;
      if_insn_q  <= if_insn_d;
      if_valid_q <= if_valid_d;
    end
  end

  assign Inst_Address      = pc_q;
  assign if_id_pc          = if_pc_q;
  assign if_id_instruction = if_insn_q;
  assign if_id_valid       = if_valid_q;
  assign fetch_fault       = (state_q == FAULT);

endmodule

// File: doc/instruction_fetch_unit.md
INSTRUCTION_FETCH_UNIT -- requirements
Module: instruction_fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 64'd0, meaning first fetch address after reset.
REQ-002 SHALL have parameter MEM_BYTES, default 88, meaning byte size of the instruction memory being fetched from.
REQ-003 SHALL use one clock and an asynchronous, active-high reset, named as below.
REQ-004 SHALL have port clk  input  1  rising-edge clock.
REQ-005 SHALL have port reset  input  1  asynchronous active-high reset.
REQ-006 SHALL have port Inst_Address  output  64  byte address driven to instruction memory; equals PC, combinational.
REQ-007 SHALL have port Instruction  input  32  little-endian word returned combinationally by memory for Inst_Address.
REQ-008 SHALL have port stall  input  1  hold PC and IF/ID register.
REQ-009 SHALL have port flush  input  1  replace IF/ID contents with a bubble.
REQ-010 SHALL have port branch_taken  input  1  redirect PC to branch_target.
REQ-011 SHALL have port branch_target  input  64  redirect byte address.
REQ-012 SHALL have port if_id_pc  output  64  PC of the captured instruction.
REQ-013 SHALL have port if_id_instruction  output  32  captured instruction.
REQ-014 SHALL have port if_id_valid  output  1  captured instruction is real (not a bubble).
REQ-015 SHALL have port fetch_fault  output  1  sticky fault indication.

Function
REQ-016 SHALL implement states BOOT, RUN, FAULT; BOOT->RUN on the first rising edge with reset low, with no capture and PC unchanged.
REQ-017 SHALL define a bubble as if_id_instruction=32'h00000013 (addi x0,x0,0), if_id_valid=0, if_id_pc unchanged.
REQ-018 SHALL, in RUN with stall=0, flush=0, branch_taken=0 and PC<=MEM_BYTES-4: capture if_id_pc<=PC, if_id_instruction<=Instruction, if_id_valid<=1, PC<=PC+4 (64-bit wraparound, no carry-out).
REQ-019 SHALL, in RUN with stall=1 and no branch_taken/flush: hold PC and all IF/ID outputs unchanged.
REQ-020 SHALL, in RUN with branch_taken=1 and branch_target[1:0]==2'b00: load PC<=branch_target and insert a bubble, regardless of stall and flush.
REQ-021 SHALL, in RUN with flush=1 and branch_taken=0: insert a bubble; PC holds if stall=1, else PC<=PC+4 without capturing.
REQ-022 SHALL, in RUN with branch_taken=1 and branch_target[1:0]!=2'b00: enter FAULT, hold PC, insert a bubble.
REQ-023 SHALL, in RUN with no redirect and PC>MEM_BYTES-4: enter FAULT, hold PC, insert a bubble, not capture Instruction.
REQ-024 SHALL, in FAULT, assert fetch_fault=1, hold PC, keep if_id_valid=0, ignore stall/flush/branch_taken; exit only by reset.
REQ-025 SHALL apply priority reset > FAULT > branch_taken > flush > stall > sequential fetch.
REQ-026 SHALL add one cycle of latency: Instruction at Inst_Address appears on if_id_* after the capturing rising edge.

Reset
REQ-027 SHALL, while reset=1 (asynchronously, including mid-fetch or in FAULT), force state=BOOT, PC=RESET_PC, if_id_pc=0, if_id_instruction=32'h00000013, if_id_valid=0, fetch_fault=0.
REQ-028 SHALL produce the first valid IF/ID word on the second rising edge after reset deasserts.

Verification
REQ-029 Reset release, memory bytes 0..15 = 83 34 85 02 / b3 84 9a 00 / 93 84 14 00 / 23 34 95 02 -> after edges 2,3,4,5: if_id_instruction = 02853483, 009A84B3, 00148493, 02953423 with if_id_pc 0,4,8,12, valid=1.
REQ-030 stall=1 for 3 cycles after PC=8 -> Inst_Address stays 8, IF/ID stays {4, 009A84B3, 1}; release -> captures 00148493 at PC 8.
REQ-031 branch_taken=1, branch_target=0 with stall=1 at PC=12 -> next edge PC=0, if_id_valid=0, if_id_instruction=00000013; following edge captures 02853483.
REQ-032 branch_taken=1, branch_target=6 -> fetch_fault=1, PC held, valid=0 thereafter despite further branches; reset pulse mid-cycle clears fault and PC=0 immediately.
REQ-033 Sequential fetch with MEM_BYTES=16 -> after capturing PC 12, PC=16 causes FAULT on next edge, no capture, fetch_fault=1.
REQ-034 flush=1 alone at PC=4 -> bubble inserted, PC=8, word at PC 4 never valid on IF/ID.
